lc3_ctrl_fsm: RTL and testbench



---
 rtl/lc3_ctrl_fsm_if.sv | 39 +++
 rtl/lc3_ctrl_fsm.sv | 240 ++++++++++++++++++++++++
 tb/tb_lc3_ctrl_fsm.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3_ctrl_fsm_if.sv
// lc3_ctrl_fsm_if
//   Bundles the LC-3 control-unit signals into one connection.
//   master : the control sequencer (drives loads, gates, mux selects, SRAM strobes)
//   slave  : the datapath / SRAM side (drives Run, Continue, IR fields and BEN)
//   Inputs to the sequencer : Run, Continue, Opcode[3:0], IR_5, IR_11, BEN
//   Outputs from sequencer  : register loads, bus gates, mux selects, ALUK,
//                             Mem_CE/UB/LB (tied low), Mem_OE/Mem_WE (active low)
interface lc3_ctrl_fsm_if;
    logic       Run;
    logic       Continue;
    logic [3:0] Opcode;
    logic       IR_5;
    logic       IR_11;
    logic       BEN;

    logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic       GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0] PCMUX;
    logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
    logic [1:0] ADDR2MUX;
    logic [1:0] ALUK;
    logic       Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;

    modport master (
        input  Run, Continue, Opcode, IR_5, IR_11, BEN,
        output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
        output GatePC, GateMDR, GateALU, GateMARMUX,
        output PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
        output Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE
    );

    modport slave (
        output Run, Continue, Opcode, IR_5, IR_11, BEN,
        input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
        input  GatePC, GateMDR, GateALU, GateMARMUX,
        input  PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
        input  Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE
    );
endinterface

// File: rtl/lc3_ctrl_fsm.sv
// lc3_ctrl_fsm
//   LC-3 instruction sequencer / control unit for the memory-class subset
//   (LD, LDI, LDR, LEA, ST, STI, STR, JSR/JSRR, JMP, BR, ADD, AND, NOT, PAUSE).
//   SRAM accesses last MEM_WAIT cycles (1..15), counted by a 4-bit wait counter.
//   Ports:
//     Clk   - system clock, all state on the rising edge
//     Reset - synchronous, active-high; returns to HALTED
//     bus   - lc3_ctrl_fsm_if.master: IR/BEN/handshake inputs, control outputs
//   Outputs depend only on the registered state and the wait counter, except for
//   the IR-field selects (SR2MUX follows IR_5, JSR_JUMP follows IR_11).
module lc3_ctrl_fsm #(
    parameter int unsigned MEM_WAIT = 2,
    parameter bit          PAUSE_EN = 1'b1
) (
    input  logic              Clk,
    input  logic              Reset,
    lc3_ctrl_fsm_if.master    bus
);

    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_LD    = 4'b0010;
    localparam logic [3:0] OP_ST    = 4'b0011;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_LDI   = 4'b1010;
    localparam logic [3:0] OP_STI   = 4'b1011;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;
    localparam logic [3:0] OP_LEA   = 4'b1110;

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);

    typedef enum logic [4:0] {
        HALTED, FETCH_MAR, FETCH_RD, FETCH_IR, DECODE,
        EX_ADD, EX_AND, EX_NOT, EX_LEA, EX_JMP,
        BR_EVAL, BR_TAKEN, JSR_SAVE, JSR_JUMP,
        ADDR_PC, ADDR_BASE, IND_RD, IND_MAR,
        MEM_RD, MEM_HOLD, MEM_WB, ST_MDR, MEM_WR,
        PAUSE1, PAUSE2
    } state_t;

    state_t     state, state_nx;
    logic [3:0] wait_cnt, wait_cnt_nx;
    logic       wait_done;

    assign wait_done = (wait_cnt == WAIT_LAST);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= HALTED;
            wait_cnt <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
        end
    end

    // Next state
    always_comb begin
        state_nx = state;
        case (state)
            HALTED:    if (bus.Run) state_nx = FETCH_MAR;
            FETCH_MAR: state_nx = FETCH_RD;
            FETCH_RD:  if (wait_done) state_nx = FETCH_IR;
            FETCH_IR:  state_nx = DECODE;
            DECODE: begin
                case (bus.Opcode)
                    OP_ADD:                         state_nx = EX_ADD;
                    OP_AND:                         state_nx = EX_AND;
                    OP_NOT:                         state_nx = EX_NOT;
                    OP_LEA:                         state_nx = EX_LEA;
                    OP_JMP:                         state_nx = EX_JMP;
                    OP_BR:                          state_nx = BR_EVAL;
                    OP_JSR:                         state_nx = JSR_SAVE;
                    OP_LD, OP_ST, OP_LDI, OP_STI:   state_nx = ADDR_PC;
                    OP_LDR, OP_STR:                 state_nx = ADDR_BASE;
                    OP_PAUSE:                       state_nx = PAUSE_EN ? PAUSE1 : FETCH_MAR;
                    default:                        state_nx = FETCH_MAR;
                endcase
            end
            EX_ADD, EX_AND, EX_NOT, EX_LEA, EX_JMP: state_nx = FETCH_MAR;
            BR_EVAL:   state_nx = bus.BEN ? BR_TAKEN : FETCH_MAR;
            BR_TAKEN:  state_nx = FETCH_MAR;
            JSR_SAVE:  state_nx = JSR_JUMP;
            JSR_JUMP:  state_nx = FETCH_MAR;
            ADDR_PC: begin
                case (bus.Opcode)
                    OP_LD:          state_nx = MEM_RD;
                    OP_ST:          state_nx = ST_MDR;
                    OP_LDI, OP_STI: state_nx = IND_RD;
                    default:        state_nx = FETCH_MAR;
                endcase
            end
            ADDR_BASE: state_nx = (bus.Opcode == OP_LDR) ? MEM_RD : ST_MDR;
            IND_RD:    if (wait_done) state_nx = IND_MAR;
            IND_MAR:   state_nx = (bus.Opcode == OP_LDI) ? MEM_RD : ST_MDR;
            // Loads spend one idle cycle between the read burst and write-back so
            // that a full load takes 2*MEM_WAIT+6 cycles including fetch.
            MEM_RD:    if (wait_done) state_nx = MEM_HOLD;
            MEM_HOLD:  state_nx = MEM_WB;
            MEM_WB:    state_nx = FETCH_MAR;
            ST_MDR:    state_nx = MEM_WR;
            MEM_WR:    if (wait_done) state_nx = FETCH_MAR;
            PAUSE1:    if (bus.Continue) state_nx = PAUSE2;
            PAUSE2:    if (!bus.Continue) state_nx = FETCH_MAR;
            default:   state_nx = HALTED;
        endcase
    end

    // Wait counter: zero on entry to any wait state, counts while staying.
    // In PAUSE1 it only marks that the entry cycle is over (LD_LED pulse).
    always_comb begin
        wait_cnt_nx = '0;
        if (state_nx == state) begin
            case (state)
                FETCH_RD, IND_RD, MEM_RD, MEM_WR: wait_cnt_nx = wait_cnt + 4'd1;
                PAUSE1:                           wait_cnt_nx = 4'd1;
                default:                          wait_cnt_nx = '0;
            endcase
        end
    end

    assign bus.Mem_CE = 1'b0;
    assign bus.Mem_UB = 1'b0;
    assign bus.Mem_LB = 1'b0;

    // Control outputs
    always_comb begin
        bus.LD_MAR     = 1'b0;
        bus.LD_MDR     = 1'b0;
        bus.LD_IR      = 1'b0;
        bus.LD_BEN     = 1'b0;
        bus.LD_CC      = 1'b0;
        bus.LD_REG     = 1'b0;
        bus.LD_PC      = 1'b0;
        bus.LD_LED     = 1'b0;
        bus.GatePC     = 1'b0;
        bus.GateMDR    = 1'b0;
        bus.GateALU    = 1'b0;
        bus.GateMARMUX = 1'b0;
        bus.PCMUX      = 2'b00;
        bus.DRMUX      = 1'b0;
        bus.SR1MUX     = 1'b0;
        bus.SR2MUX     = 1'b0;
        bus.ADDR1MUX   = 1'b0;
        bus.ADDR2MUX   = 2'b00;
        bus.ALUK       = 2'b00;
        bus.Mem_OE     = 1'b1;
        bus.Mem_WE     = 1'b1;
        case (state)
            FETCH_MAR: begin
                bus.GatePC = 1'b1;
                bus.LD_MAR = 1'b1;
                bus.LD_PC  = 1'b1;
                bus.PCMUX  = 2'b10;
            end
            FETCH_RD, IND_RD, MEM_RD: begin
                bus.Mem_OE = 1'b0;
                bus.LD_MDR = wait_done;
            end
            FETCH_IR: begin
                bus.GateMDR = 1'b1;
                bus.LD_IR   = 1'b1;
            end
            DECODE: bus.LD_BEN = 1'b1;
            EX_ADD, EX_AND, EX_NOT: begin
                bus.SR2MUX  = bus.IR_5;
                bus.ALUK    = (state == EX_ADD) ? 2'b00 :
                              (state == EX_AND) ? 2'b01 : 2'b11;
                bus.GateALU = 1'b1;
                bus.LD_REG  = 1'b1;
                bus.LD_CC   = 1'b1;
            end
            EX_LEA: begin
                bus.ADDR1MUX   = 1'b1;
                bus.ADDR2MUX   = 2'b01;
                bus.GateMARMUX = 1'b1;
                bus.LD_REG     = 1'b1;
                bus.LD_CC      = 1'b1;
            end
            EX_JMP: begin
                bus.ALUK    = 2'b10;
                bus.GateALU = 1'b1;
                bus.PCMUX   = 2'b00;
                bus.LD_PC   = 1'b1;
            end
            BR_TAKEN: begin
                bus.PCMUX    = 2'b01;
                bus.ADDR1MUX = 1'b1;
                bus.ADDR2MUX = 2'b01;
                bus.LD_PC    = 1'b1;
            end
            JSR_SAVE: begin
                bus.GatePC = 1'b1;
                bus.DRMUX  = 1'b1;
                bus.LD_REG = 1'b1;
            end
            JSR_JUMP: begin
                bus.PCMUX    = 2'b01;
                bus.ADDR1MUX = bus.IR_11;
                bus.ADDR2MUX = bus.IR_11 ? 2'b00 : 2'b11;
                bus.LD_PC    = 1'b1;
            end
            ADDR_PC: begin
                bus.ADDR1MUX   = 1'b1;
                bus.ADDR2MUX   = 2'b01;
                bus.GateMARMUX = 1'b1;
                bus.LD_MAR     = 1'b1;
            end
            ADDR_BASE: begin
                bus.ADDR2MUX   = 2'b10;
                bus.GateMARMUX = 1'b1;
                bus.LD_MAR     = 1'b1;
            end
            IND_MAR: begin
                bus.GateMDR = 1'b1;
                bus.LD_MAR  = 1'b1;
            end
            MEM_WB: begin
                bus.GateMDR = 1'b1;
                bus.LD_REG  = 1'b1;
                bus.LD_CC   = 1'b1;
            end
            ST_MDR: begin
                bus.SR1MUX  = 1'b1;
                bus.ALUK    = 2'b10;
                bus.GateALU = 1'b1;
                bus.LD_MDR  = 1'b1;
            end
            MEM_WR: bus.Mem_WE = 1'b0;
            PAUSE1: bus.LD_LED = (wait_cnt == 4'd0);
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lc3_ctrl_fsm.sv
// tb_lc3_ctrl_fsm
//   Directed bench for lc3_ctrl_fsm. Three instances share one set of inputs:
//     A: MEM_WAIT=2, PAUSE_EN=1   B: MEM_WAIT=4, PAUSE_EN=0   C: MEM_WAIT=1, PAUSE_EN=1
//   The instance under observation is chosen with sel; its outputs are packed
//   into a ctl_t and compared against hand-built expected vectors.
module tb_lc3_ctrl_fsm;

    typedef struct packed {
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux;
        logic       drmux, sr1mux, sr2mux, addr1mux;
        logic [1:0] addr2mux;
        logic [1:0] aluk;
        logic       mem_oe, mem_we, mem_ce, mem_ub, mem_lb;
    } ctl_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       cont = 1'b0;
    logic [3:0] opc = 4'b0001;
    logic       ir5 = 1'b0;
    logic       ir11 = 1'b0;
    logic       ben = 1'b0;

    int nerr = 0;
    int nchk = 0;
    int sel = 0;
    int w = 2;

    ctl_t ca, cb, cc, cur;

    always #5 clk = ~clk;

    lc3_ctrl_fsm_if ifa ();
    lc3_ctrl_fsm_if ifb ();
    lc3_ctrl_fsm_if ifc ();

    assign ifa.Run = run;  assign ifa.Continue = cont; assign ifa.Opcode = opc;
    assign ifa.IR_5 = ir5; assign ifa.IR_11 = ir11;    assign ifa.BEN = ben;
    assign ifb.Run = run;  assign ifb.Continue = cont; assign ifb.Opcode = opc;
    assign ifb.IR_5 = ir5; assign ifb.IR_11 = ir11;    assign ifb.BEN = ben;
    assign ifc.Run = run;  assign ifc.Continue = cont; assign ifc.Opcode = opc;
    assign ifc.IR_5 = ir5; assign ifc.IR_11 = ir11;    assign ifc.BEN = ben;

    lc3_ctrl_fsm #(.MEM_WAIT(2), .PAUSE_EN(1'b1)) dut_a (.Clk(clk), .Reset(rst), .bus(ifa));
    lc3_ctrl_fsm #(.MEM_WAIT(4), .PAUSE_EN(1'b0)) dut_b (.Clk(clk), .Reset(rst), .bus(ifb));
    lc3_ctrl_fsm #(.MEM_WAIT(1), .PAUSE_EN(1'b1)) dut_c (.Clk(clk), .Reset(rst), .bus(ifc));

    assign ca = {ifa.LD_MAR, ifa.LD_MDR, ifa.LD_IR, ifa.LD_BEN, ifa.LD_CC, ifa.LD_REG, ifa.LD_PC, ifa.LD_LED,
                 ifa.GatePC, ifa.GateMDR, ifa.GateALU, ifa.GateMARMUX, ifa.PCMUX, ifa.DRMUX, ifa.SR1MUX,
                 ifa.SR2MUX, ifa.ADDR1MUX, ifa.ADDR2MUX, ifa.ALUK, ifa.Mem_OE, ifa.Mem_WE, ifa.Mem_CE,
                 ifa.Mem_UB, ifa.Mem_LB};
    assign cb = {ifb.LD_MAR, ifb.LD_MDR, ifb.LD_IR, ifb.LD_BEN, ifb.LD_CC, ifb.LD_REG, ifb.LD_PC, ifb.LD_LED,
                 ifb.GatePC, ifb.GateMDR, ifb.GateALU, ifb.GateMARMUX, ifb.PCMUX, ifb.DRMUX, ifb.SR1MUX,
                 ifb.SR2MUX, ifb.ADDR1MUX, ifb.ADDR2MUX, ifb.ALUK, ifb.Mem_OE, ifb.Mem_WE, ifb.Mem_CE,
                 ifb.Mem_UB, ifb.Mem_LB};
    assign cc = {ifc.LD_MAR, ifc.LD_MDR, ifc.LD_IR, ifc.LD_BEN, ifc.LD_CC, ifc.LD_REG, ifc.LD_PC, ifc.LD_LED,
                 ifc.GatePC, ifc.GateMDR, ifc.GateALU, ifc.GateMARMUX, ifc.PCMUX, ifc.DRMUX, ifc.SR1MUX,
                 ifc.SR2MUX, ifc.ADDR1MUX, ifc.ADDR2MUX, ifc.ALUK, ifc.Mem_OE, ifc.Mem_WE, ifc.Mem_CE,
                 ifc.Mem_UB, ifc.Mem_LB};

    always_comb begin
        case (sel)
            0:       cur = ca;
            1:       cur = cb;
            default: cur = cc;
        endcase
    end

    function automatic ctl_t dflt();
        ctl_t c;
        c = '0;
        c.mem_oe = 1'b1;
        c.mem_we = 1'b1;
        return c;
    endfunction

    function automatic ctl_t fm_vec();
        ctl_t c;
        c = dflt();
        c.gate_pc = 1'b1; c.ld_mar = 1'b1; c.ld_pc = 1'b1; c.pcmux = 2'b10;
        return c;
    endfunction

    function automatic bit is_fm(ctl_t c);
        return c.gate_pc && c.ld_mar && c.ld_pc && (c.pcmux == 2'b10);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input ctl_t obs, input ctl_t exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // From a FETCH_MAR cycle, run to the next FETCH_MAR and collect statistics.
    task automatic period(output int n, output int oe, output int we, output int ovl, output int led);
        n = 0; oe = 0; we = 0; ovl = 0; led = 0;
        do begin
            tick();
            n++;
            if (cur.mem_oe == 1'b0) oe++;
            if (cur.mem_we == 1'b0) we++;
            if (cur.mem_oe == 1'b0 && cur.mem_we == 1'b0) ovl++;
            if (cur.ld_led) led++;
        end while (!is_fm(cur) && n < 80);
        if (n >= 80) chk_int("period_timeout", n, -1);
    endtask

    task automatic restart(input int s, input int wv);
        sel = s;
        w = wv;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run = 1'b1;
        tick();
        run = 1'b0;
        chk("restart_fetch_mar", cur, fm_vec());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ctl_t e;
        int n, oe, we, ovl, led;

        // ---------------- Instance A: MEM_WAIT=2 ----------------
        sel = 0; w = 2;
        rst = 1'b1;
        tick();
        chk("reset_a", ca, dflt());
        chk("reset_b", cb, dflt());
        chk("reset_c", cc, dflt());
        rst = 1'b0;
        tick();
        chk("halted_idle", cur, dflt());
        run = 1'b1;
        tick();
        run = 1'b0;
        chk("fetch_mar", cur, fm_vec());

        // ADD R1,R2,R3 (0x1283): IR_5=0
        tick(); e = dflt(); e.mem_oe = 1'b0;                  chk("add_rd0", cur, e);
        tick(); e.ld_mdr = 1'b1;                              chk("add_rd1", cur, e);
        tick(); e = dflt(); e.gate_mdr = 1'b1; e.ld_ir = 1'b1; chk("add_fetch_ir", cur, e);
        tick(); e = dflt(); e.ld_ben = 1'b1;                  chk("add_decode", cur, e);
        tick(); e = dflt(); e.gate_alu = 1'b1; e.ld_reg = 1'b1; e.ld_cc = 1'b1;
        chk("add_exec", cur, e);
        tick();                                               chk("add_next_fm", cur, fm_vec());

        // AND with immediate
        opc = 4'b0101; ir5 = 1'b1;
        repeat (w + 3) tick();
        e = dflt(); e.aluk = 2'b01; e.sr2mux = 1'b1; e.gate_alu = 1'b1; e.ld_reg = 1'b1; e.ld_cc = 1'b1;
        chk("and_exec", cur, e);
        tick(); chk("and_next_fm", cur, fm_vec());

        // NOT
        opc = 4'b1001; ir5 = 1'b0;
        repeat (w + 3) tick();
        e = dflt(); e.aluk = 2'b11; e.gate_alu = 1'b1; e.ld_reg = 1'b1; e.ld_cc = 1'b1;
        chk("not_exec", cur, e);
        tick(); chk("not_next_fm", cur, fm_vec());

        // LEA
        opc = 4'b1110;
        repeat (w + 3) tick();
        e = dflt(); e.addr1mux = 1'b1; e.addr2mux = 2'b01; e.gate_marmux = 1'b1; e.ld_reg = 1'b1; e.ld_cc = 1'b1;
        chk("lea_exec", cur, e);
        tick();
        period(n, oe, we, ovl, led);
        chk_int("lea_cycles", n, w + 4);

        // JMP
        opc = 4'b1100;
        repeat (w + 3) tick();
        e = dflt(); e.aluk = 2'b10; e.gate_alu = 1'b1; e.pcmux = 2'b00; e.ld_pc = 1'b1;
        chk("jmp_exec", cur, e);
        tick(); chk("jmp_next_fm", cur, fm_vec());

        // BR not taken / taken
        opc = 4'b0000; ben = 1'b0;
        period(n, oe, we, ovl, led);
        chk_int("br_nt_cycles", n, w + 4);
        ben = 1'b1;
        period(n, oe, we, ovl, led);
        chk_int("br_t_cycles", n, w + 5);
        repeat (w + 4) tick();
        e = dflt(); e.pcmux = 2'b01; e.addr1mux = 1'b1; e.addr2mux = 2'b01; e.ld_pc = 1'b1;
        chk("br_taken", cur, e);
        tick(); chk("br_next_fm", cur, fm_vec());
        ben = 1'b0;

        // JSR (IR_11=1) then JSRR (IR_11=0)
        opc = 4'b0100; ir11 = 1'b1;
        repeat (w + 3) tick();
        e = dflt(); e.gate_pc = 1'b1; e.drmux = 1'b1; e.ld_reg = 1'b1;
        chk("jsr_save", cur, e);
        tick();
        e = dflt(); e.pcmux = 2'b01; e.addr1mux = 1'b1; e.addr2mux = 2'b00; e.ld_pc = 1'b1;
        chk("jsr_jump", cur, e);
        tick(); chk("jsr_next_fm", cur, fm_vec());
        ir11 = 1'b0;
        repeat (w + 4) tick();
        e = dflt(); e.pcmux = 2'b01; e.addr1mux = 1'b0; e.addr2mux = 2'b11; e.ld_pc = 1'b1;
        chk("jsrr_jump", cur, e);
        tick(); chk("jsrr_next_fm", cur, fm_vec());
        period(n, oe, we, ovl, led);
        chk_int("jsr_cycles", n, w + 5);

        // LD, LDR, ST
        opc = 4'b0010;
        period(n, oe, we, ovl, led);
        chk_int("ld_cycles", n, 2 * w + 6);
        chk_int("ld_oe_cycles", oe, 2 * w);
        opc = 4'b0110;
        repeat (w + 3) tick();
        e = dflt(); e.addr2mux = 2'b10; e.gate_marmux = 1'b1; e.ld_mar = 1'b1;
        chk("ldr_addr", cur, e);
        repeat (w + 3) tick();
        chk("ldr_next_fm", cur, fm_vec());
        opc = 4'b0011;
        period(n, oe, we, ovl, led);
        chk_int("st_cycles", n, 2 * w + 5);
        chk_int("st_we_cycles", we, w);

        // PAUSE: LD_LED on entry only, released by Continue rise then fall
        opc = 4'b1101; cont = 1'b0;
        repeat (w + 3) tick();
        e = dflt(); e.ld_led = 1'b1;
        chk("pause_led", cur, e);
        opc = 4'b0001;
        tick(); chk("pause_hold", cur, dflt());
        repeat (3) tick();
        chk("pause_hold_long", cur, dflt());
        cont = 1'b1;
        tick(); chk("pause2", cur, dflt());
        tick(); chk("pause2_hold", cur, dflt());
        cont = 1'b0;
        tick(); chk("pause_release_fm", cur, fm_vec());

        // ---------------- Instance B: MEM_WAIT=4, PAUSE_EN=0 ----------------
        opc = 4'b1010;
        restart(1, 4);
        period(n, oe, we, ovl, led);
        chk_int("ldi_cycles", n, 19);
        chk_int("ldi_oe_cycles", oe, 12);
        repeat (12) tick();
        e = dflt(); e.gate_mdr = 1'b1; e.ld_mar = 1'b1;
        chk("ldi_ind_mar", cur, e);
        repeat (6) tick();
        e = dflt(); e.gate_mdr = 1'b1; e.ld_reg = 1'b1; e.ld_cc = 1'b1;
        chk("ldi_mem_wb", cur, e);
        tick(); chk("ldi_next_fm", cur, fm_vec());

        opc = 4'b1101;
        period(n, oe, we, ovl, led);
        chk_int("nop_cycles", n, w + 3);
        chk_int("nop_led", led, 0);

        // Reset during the third cycle of a fetch read
        repeat (3) tick();
        e = dflt(); e.mem_oe = 1'b0;
        chk("abort_pre", cur, e);
        rst = 1'b1;
        tick(); chk("abort_reset", cur, dflt());
        rst = 1'b0;
        tick(); chk("abort_halted", cur, dflt());

        // ---------------- Instance C: MEM_WAIT=1 ----------------
        opc = 4'b0111;
        restart(2, 1);
        repeat (5) tick();
        e = dflt(); e.sr1mux = 1'b1; e.aluk = 2'b10; e.gate_alu = 1'b1; e.ld_mdr = 1'b1;
        chk("str_st_mdr", cur, e);
        tick();
        e = dflt(); e.mem_we = 1'b0;
        chk("str_mem_wr", cur, e);
        tick(); chk("str_next_fm", cur, fm_vec());
        opc = 4'b1011;
        period(n, oe, we, ovl, led);
        chk_int("sti_cycles", n, 3 * w + 6);
        chk_int("sti_we_cycles", we, 1);
        chk_int("sti_oe_cycles", oe, 2);
        chk_int("sti_overlap", ovl, 0);
        opc = 4'b0010;
        period(n, oe, we, ovl, led);
        chk_int("ld_w1_cycles", n, 2 * w + 6);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
